// File: rtl/dac_mix_sched.sv
// Frame scheduler: polls NUM_CH sources round-robin per `next` pulse and presents the mixed stereo pair.
// Optional DAC_MIX_SAT_EN: saturating unity-gain mix; otherwise the sum is scaled by 1/2**CH_BITS.
module dac_mix_sched #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next,
  output logic               req,
  output logic [CH_BITS-1:0] ch_sel,
  input  logic               ack,
  input  logic [15:0]        ch_l,
  input  logic [15:0]        ch_r,
  output logic [15:0]        sample_l,
  output logic [15:0]        sample_r,
  output logic               frame_done,
  output logic               overrun
);

  localparam int AW = 16 + CH_BITS;
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, POLL, COMMIT} state_t;

  state_t               state, state_nxt;
  logic signed [AW-1:0] acc_l, acc_r;
  logic                 start, xfer, commit, last;
  logic [15:0]          mix_l, mix_r;

  assign last = (ch_sel == LAST_CH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    start     = 1'b0;
    xfer      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (next) begin
          start     = 1'b1;
          state_nxt = POLL;
        end
      end
      POLL: begin
        req = 1'b1;
        if (ack) begin
          xfer = 1'b1;
          if (last) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DAC_MIX_SAT_EN
  function automatic logic [15:0] sat16(input logic signed [AW-1:0] a);
    if (a[AW-1:15] == '0 || a[AW-1:15] == '1) return a[15:0];
    else if (a[AW-1])                           return 16'h8000;
    else                                        return 16'h7FFF;
  endfunction

  always_comb begin
    mix_l = sat16(acc_l);
    mix_r = sat16(acc_r);
  end
`else
  // Slicing above the headroom bits equals acc >>> CH_BITS truncated to 16 bits.
  always_comb begin
    mix_l = acc_l[CH_BITS +: 16];
    mix_r = acc_r[CH_BITS +: 16];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_sel     <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      sample_l   <= '0;
      sample_r   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= commit;
      // A pulse landing in POLL or COMMIT is dropped, never queued.
      overrun    <= next && (state != IDLE);
      if (start) begin
        ch_sel <= '0;
        acc_l  <= '0;
        acc_r  <= '0;
      end
      if (xfer) begin
        acc_l <= acc_l + {{CH_BITS{ch_l[15]}}, ch_l};
        acc_r <= acc_r + {{CH_BITS{ch_r[15]}}, ch_r};
        if (!last) ch_sel <= ch_sel + CH_BITS'(1);
      end
      if (commit) begin
        sample_l <= mix_l;
        sample_r <= mix_r;
      end
    end
  end

endmodule

// File: tb/tb_dac_mix_sched.sv
// Bench for dac_mix_sched: integer frame model compared every cycle, plus directed literal checks.
// Honours DAC_MIX_SAT_EN the same way as the design.
module tb_dac_mix_sched;
  localparam int NUM_CH  = 4;
  localparam int CH_BITS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        next = 1'b0;
  logic        ack = 1'b0;
  logic        req;
  logic [1:0]  ch_sel;
  logic [15:0] ch_l, ch_r, sample_l, sample_r;
  logic        frame_done, overrun;

  logic signed [15:0] src_l [NUM_CH];
  logic signed [15:0] src_r [NUM_CH];

  assign ch_l = src_l[ch_sel];
  assign ch_r = src_r[ch_sel];

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model: busy polling, commit pending, running integer sums.
  bit          m_busy = 0, m_commit = 0, m_fd = 0, m_ov = 0;
  int          m_idx = 0, m_sum_l = 0, m_sum_r = 0;
  logic [15:0] m_sl = '0, m_sr = '0;

  int stall_ch = -1;
  int stall_left = 0;
  int held2 = 0;

  dac_mix_sched #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) dut (
    .clk(clk), .reset(reset), .next(next), .req(req), .ch_sel(ch_sel), .ack(ack),
    .ch_l(ch_l), .ch_r(ch_r), .sample_l(sample_l), .sample_r(sample_r),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mixf(input int s);
`ifdef DAC_MIX_SAT_EN
    if (s > 32767)       return 16'h7FFF;
    else if (s < -32768) return 16'h8000;
    else                 return 16'(s);
`else
    return 16'(s >>> CH_BITS);
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_commit = 0; m_fd = 0; m_ov = 0;
      m_idx = 0; m_sum_l = 0; m_sum_r = 0; m_sl = '0; m_sr = '0;
    end else begin
      m_ov = next && (m_busy || m_commit);
      m_fd = 0;
      if (m_commit) begin
        m_sl = mixf(m_sum_l);
        m_sr = mixf(m_sum_r);
        m_fd = 1;
        m_commit = 0;
      end else if (m_busy) begin
        if (ack) begin
          m_sum_l += int'(src_l[m_idx]);
          m_sum_r += int'(src_r[m_idx]);
          if (m_idx == NUM_CH - 1) begin
            m_busy = 0;
            m_commit = 1;
          end else begin
            m_idx++;
          end
        end
      end else if (next) begin
        m_busy = 1; m_idx = 0; m_sum_l = 0; m_sum_r = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs against the model, then drive inputs for the next edge.
  task automatic tick(input bit nx, input bit ak, input bit rs);
    bit a;
    @(negedge clk);
    chk("req", int'(req), int'(m_busy));
    chk("ch_sel", int'(ch_sel), m_idx);
    chk("sample_l", int'(sample_l), int'(m_sl));
    chk("sample_r", int'(sample_r), int'(m_sr));
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("overrun", int'(overrun), int'(m_ov));
    if (req && ch_sel == 2'd2) held2++;
    a = ak;
    if (req && int'(ch_sel) == stall_ch && stall_left > 0) begin
      a = 1'b0;
      stall_left--;
    end
    next = nx; ack = a; reset = rs;
  endtask

  task automatic fill(input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i < NUM_CH; i++) begin
      src_l[i] = l;
      src_r[i] = r;
    end
  endtask

  initial begin
    int lat, n_ov, n_fd;
    logic [15:0] e_l, e_r;
    fill(16'h0000, 16'h0000);

    // 1: reset held three cycles while next pulses
    tick(1, 1, 1); tick(0, 1, 1); tick(1, 1, 1);
    tick(0, 0, 0);
    chk("rst_req", int'(req), 0);
    chk("rst_sample_l", int'(sample_l), 0);
    chk("rst_sample_r", int'(sample_r), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    tick(0, 0, 0);

    // 2: mix with immediate ack, latency next -> frame_done
    fill(16'h1000, 16'hF000);
    tick(1, 1, 0);
    lat = 0;
    do begin
      tick(0, 1, 0);
      lat++;
    end while (!frame_done && lat < 20);
    chk("latency", lat, 6);
`ifdef DAC_MIX_SAT_EN
    e_l = 16'h4000; e_r = 16'hC000;
`else
    e_l = 16'h1000; e_r = 16'hF000;
`endif
    chk("mix_l", int'(sample_l), int'(e_l));
    chk("mix_r", int'(sample_r), int'(e_r));
    tick(0, 0, 0);

    // 3: extremes; both gain modes land on the rails
    fill(16'h7FFF, 16'h8000);
    tick(1, 1, 0);
    for (int i = 0; i < 20 && !frame_done; i++) tick(0, 1, 0);
    chk("sat_l", int'(sample_l), 32'h7FFF);
    chk("sat_r", int'(sample_r), 32'h8000);
    tick(0, 0, 0);

    // 4: five-cycle stall on channel 2; sum -5 also exercises floor rounding
    src_l[0] = 16'sd100; src_l[1] = -16'sd200; src_l[2] = 16'sd300; src_l[3] = 16'sd1000;
    src_r[0] = -16'sd1;  src_r[1] = -16'sd1;   src_r[2] = -16'sd1;  src_r[3] = -16'sd2;
    stall_ch = 2; stall_left = 5; held2 = 0;
    tick(1, 1, 0);
    for (int i = 0; i < 30 && !frame_done; i++) tick(0, 1, 0);
    chk("stall_fd", int'(frame_done), 1);
    // five stalled cycles plus the transfer cycle itself
    chk("stall_held", held2, 6);
`ifdef DAC_MIX_SAT_EN
    e_l = 16'h04B0; e_r = 16'hFFFB;
`else
    e_l = 16'h012C; e_r = 16'hFFFE;
`endif
    chk("stall_l", int'(sample_l), int'(e_l));
    chk("stall_r", int'(sample_r), int'(e_r));
    stall_ch = -1; stall_left = 0;
    tick(0, 0, 0);

    // 5: second next while ch_sel=1
    fill(16'h0123, 16'hFEDC);
    tick(1, 1, 0);
    for (int i = 0; i < 20 && !(req && ch_sel == 2'd1); i++) tick(0, 1, 0);
    chk("reach_ch1", int'(req && ch_sel == 2'd1), 1);
    tick(1, 1, 0);
    n_ov = 0; n_fd = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, 0);
      n_ov += int'(overrun);
      n_fd += int'(frame_done);
    end
    chk("ovr_pulses", n_ov, 1);
    chk("ovr_frames", n_fd, 1);

    // next coinciding with COMMIT: overrun, no restart
    tick(1, 1, 0);
    repeat (4) tick(0, 1, 0);
    tick(1, 1, 0);
    tick(0, 1, 0);
    chk("commit_fd", int'(frame_done), 1);
    chk("commit_ovr", int'(overrun), 1);
    tick(0, 1, 0);
    chk("commit_norestart", int'(req), 0);

    // 6: abort with reset at ch_sel=2
    tick(1, 1, 0);
    for (int i = 0; i < 20 && !(req && ch_sel == 2'd2); i++) tick(0, 1, 0);
    chk("reach_ch2", int'(req && ch_sel == 2'd2), 1);
    tick(0, 1, 1);
    tick(0, 0, 0);
    chk("abort_req", int'(req), 0);
    chk("abort_l", int'(sample_l), 0);
    chk("abort_r", int'(sample_r), 0);
    tick(1, 1, 0);
    tick(0, 1, 0);
    chk("restart_ch", int'(ch_sel), 0);
    chk("restart_req", int'(req), 1);
    for (int i = 0; i < 10; i++) tick(0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        src_l[c] = 16'($urandom);
        src_r[c] = 16'($urandom);
      end
      tick(($urandom % 8) == 0, ($urandom % 3) != 0, ($urandom % 150) == 0);
    end
    tick(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
